corr_controller: RTL and testbench
==================================

Name: corr_controller

Overview:
- Control FSM for the 2-D correlation engine: 4x4 filter swept over a 16x16 byte image, producing 13x13 byte results.
- Drives every control strobe of the correlation datapath and the shared 32-bit word memory.
- Sequences: filter load, input-band load, per-window MAC, result packing/write, band shift, done.
- Consumes the datapath's carry/status flags; sits directly upstream of the datapath.

Parameters:
ROW_WORDS, 4, memory words per image row (16 bytes)
CNT_W, 20, width of optional performance counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  begin a run (sampled in IDLE only)
filt_cout, input_j_cout, calc_done, write_mem_cout, table_cout, it_ends  input  1 each  datapath status flags
x_sel, y_sel, z_sel  output  1 each  address reg source: 0=load base, 1=increment
x_en, y_en, z_en  output  1 each  address reg enables (x=filter, y=image, z=result)
mem_in_sel  output  2  address mux: 0=x, 1=y, 2=z
mem_read, mem_write  output  1 each  memory strobes
filt_ld, filt_count_en, filt_row_sel  output  1 each  filter buffer load/count; row_sel 1 during CALC
input_en, input_count_en  output  1 each  input band buffer write/word count
input_i_sel  output  2  band row being written
shift_en, in_count_en, in_count_ld  output  1 each  band shift and band counter
tab_count_ld, count_13_en, table_ld  output  1 each  window counter load/step, window capture
mac_rst, mac_ld, calc_count_en  output  1 each  MAC clear/accumulate, 4x4 index step
write_buf_ld, wr_count_en, wr_data_sel  output  1 each  result packing; wr_data_sel=1 for partial word
done  output  1  run complete

Behaviour:
- Reset (rst=0, async): state=IDLE, row counter=0, last_win=0; every output 0.
- All outputs are Moore decodes of state/phase, so no combinational path exists from inputs to outputs.
- Memory read is synchronous: address is presented with mem_read in phase A; data is captured in phase B (next cycle). One word takes 2 cycles.
- IDLE: on start=1, one INIT cycle follows:
  - x_en, y_en, z_en=1 with *_sel=0 to load base addresses.
  - in_count_ld=1, tab_count_ld=1 (counters load 3).
  - mac_rst=1.
- RD_FILT: phase A: mem_in_sel=0, mem_read. Phase B: filt_ld, filt_count_en, x_en, x_sel=1. Exit to RD_ROWS after the phase B in which filt_cout=1 (4 words, 8 cycles).
- RD_ROWS: phase A: mem_in_sel=1, mem_read. Phase B: input_en, input_count_en, y_en, y_sel=1, input_i_sel=row.
  - When input_j_cout=1 in phase B, row increments.
  - After row 3 completes: LD_TAB (32 cycles total).
- LD_TAB: 1 cycle; table_ld=1, mac_rst=1.
- CALC: mac_ld, calc_count_en, filt_row_sel=1. Leaves to STORE on the cycle calc_done=1 (16 cycles).
- STORE: 1 cycle; write_buf_ld, wr_count_en, count_13_en. last_win<=table_cout.
  - If write_mem_cout or table_cout: go to WR_MEM.
  - Otherwise: go to LD_TAB.
- WR_MEM: 1 cycle; mem_in_sel=2, mem_write, z_en, z_sel=1, wr_data_sel=last_win.
  - If last_win: go to PAD.
  - Otherwise: go to LD_TAB.
- PAD: 3 cycles of wr_count_en only, realigning the write byte counter (13 mod 4 = 1, +3 wraps to 0).
  - If it_ends was seen at STORE: go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT: 1 cycle; shift_en, in_count_en, tab_count_ld; row forced to 3. Then 4 words via RD_ROWS phases (row stays 3), then LD_TAB.
- DONE: done=1 held until start=0, then IDLE.
- Boundaries:
  - start is ignored outside IDLE.
  - start held high through DONE does not retrigger.
  - Reset mid-run aborts immediately; no memory write is issued after rst falls.
  - Simultaneous write_mem_cout and table_cout: a single write with wr_data_sel=1.

Optional Feature:
CORR_PERF_CNT_EN
- Defined: adds output cycle_cnt[CNT_W-1:0]. It clears at INIT, increments every cycle while not IDLE/DONE, holds in DONE, saturates at all-ones, and resets to 0.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package corr_ctrl_pkg: state encoding (IDLE, INIT, RD_FILT, RD_ROWS, LD_TAB, CALC, STORE, WR_MEM, PAD, SHIFT, DONE); address-mux codes SEL_X=0, SEL_Y=1, SEL_Z=2; PAD_CYCLES=3; LAST_ROW=2'd3.
- Sub-module band_row_ctr: 2-bit row counter with clear, force-to-3 and increment.

Test Plan:
- Reset and start: rst=0 mid-CALC, then release → all outputs 0; IDLE holds until start; INIT asserts x/y/z_en with sel=0.
- Filter load: start, with filt_cout on the 4th phase B → exactly 4 mem_read pulses with mem_in_sel=0, 8 cycles, then RD_ROWS.
- Window: calc_done after 16 CALC cycles, write_mem_cout on the 4th STORE → 16 mac_ld pulses, then a mem_write with mem_in_sel=2 and wr_data_sel=0.
- Band end: table_cout at the 13th STORE → WR_MEM with wr_data_sel=1, 3 PAD wr_count_en pulses, SHIFT with shift_en=1, 4 reads into input_i_sel=3.
- Full run with model datapath → 13 bands, 52 mem_write pulses (13 of them partial), done=1 and held until start=0.
- With CORR_PERF_CNT_EN: cycle_cnt at DONE equals the model-computed cycle count and stays stable through DONE.

Source files
------------

// File: rtl/corr_ctrl_pkg.sv
// Shared types and constants for the correlation-engine control FSM.
package corr_ctrl_pkg;

  localparam int unsigned ROW_WORDS  = 4;
  localparam int unsigned CNT_W      = 20;
  localparam int unsigned PAD_CYCLES = 3;

  localparam logic [1:0] LAST_ROW = 2'd3;
  localparam logic [1:0] SEL_X    = 2'd0;
  localparam logic [1:0] SEL_Y    = 2'd1;
  localparam logic [1:0] SEL_Z    = 2'd2;

  typedef enum logic [3:0] {
    IDLE, INIT, RD_FILT, RD_ROWS, LD_TAB, CALC, STORE, WR_MEM, PAD, SHIFT, DONE
  } state_t;

  // Every strobe the controller drives toward the datapath and memory.
  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       z_sel;
    logic       x_en;
    logic       y_en;
    logic       z_en;
    logic [1:0] mem_in_sel;
    logic       mem_read;
    logic       mem_write;
    logic       filt_ld;
    logic       filt_count_en;
    logic       filt_row_sel;
    logic       input_en;
    logic       input_count_en;
    logic [1:0] input_i_sel;
    logic       shift_en;
    logic       in_count_en;
    logic       in_count_ld;
    logic       tab_count_ld;
    logic       count_13_en;
    logic       table_ld;
    logic       mac_rst;
    logic       mac_ld;
    logic       calc_count_en;
    logic       write_buf_ld;
    logic       wr_count_en;
    logic       wr_data_sel;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/corr_controller_if.sv
// Controller <-> datapath bundle: status flags in, control strobes out.
interface corr_controller_if;

  logic       filt_cout;
  logic       input_j_cout;
  logic       calc_done;
  logic       write_mem_cout;
  logic       table_cout;
  logic       it_ends;

  logic       x_sel;
  logic       y_sel;
  logic       z_sel;
  logic       x_en;
  logic       y_en;
  logic       z_en;
  logic [1:0] mem_in_sel;
  logic       mem_read;
  logic       mem_write;
  logic       filt_ld;
  logic       filt_count_en;
  logic       filt_row_sel;
  logic       input_en;
  logic       input_count_en;
  logic [1:0] input_i_sel;
  logic       shift_en;
  logic       in_count_en;
  logic       in_count_ld;
  logic       tab_count_ld;
  logic       count_13_en;
  logic       table_ld;
  logic       mac_rst;
  logic       mac_ld;
  logic       calc_count_en;
  logic       write_buf_ld;
  logic       wr_count_en;
  logic       wr_data_sel;

  modport master (
    input  filt_cout, input_j_cout, calc_done, write_mem_cout, table_cout, it_ends,
    output x_sel, y_sel, z_sel, x_en, y_en, z_en, mem_in_sel, mem_read, mem_write,
           filt_ld, filt_count_en, filt_row_sel, input_en, input_count_en, input_i_sel,
           shift_en, in_count_en, in_count_ld, tab_count_ld, count_13_en, table_ld,
           mac_rst, mac_ld, calc_count_en, write_buf_ld, wr_count_en, wr_data_sel
  );

  modport slave (
    output filt_cout, input_j_cout, calc_done, write_mem_cout, table_cout, it_ends,
    input  x_sel, y_sel, z_sel, x_en, y_en, z_en, mem_in_sel, mem_read, mem_write,
           filt_ld, filt_count_en, filt_row_sel, input_en, input_count_en, input_i_sel,
           shift_en, in_count_en, in_count_ld, tab_count_ld, count_13_en, table_ld,
           mac_rst, mac_ld, calc_count_en, write_buf_ld, wr_count_en, wr_data_sel
  );

endinterface

// File: rtl/corr_controller_band_row_ctr.sv
// band_row_ctr: 2-bit index of the band row being written; clear, jump to last row, or step.
module band_row_ctr
  import corr_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       set_last,
  input  logic       inc,
  output logic [1:0] row
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= 2'd0;
    end else if (clr) begin
      row <= 2'd0;
    end else if (set_last) begin
      row <= LAST_ROW;
    end else if (inc) begin
      row <= row + 2'd1;
    end
  end

endmodule

// File: rtl/corr_controller.sv
// corr_controller: sequences filter load, band load, 4x4 MAC windows, result writes and band
// shifts for the 2-D correlation engine. Optional cycle counter enabled by CORR_PERF_CNT_EN.
module corr_controller
  import corr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  corr_controller_if.master dp,
`ifdef CORR_PERF_CNT_EN
  output logic [CNT_W-1:0]  cycle_cnt,
`endif
  output logic              done
);

  state_t     state, state_next;
  logic       phase_b, phase_b_next;
  logic       last_win, last_win_next;
  logic       ends_seen, ends_seen_next;
  logic [1:0] pad_cnt, pad_cnt_next;
  logic [1:0] row;
  logic       row_clr, row_set_last, row_inc;
  ctrl_t      ctrl_d, ctrl_q;

  band_row_ctr u_row (
    .clk      (clk),
    .rst      (rst),
    .clr      (row_clr),
    .set_last (row_set_last),
    .inc      (row_inc),
    .row      (row)
  );

  // Outputs are decoded from the next state and registered, so they track state exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase_b   <= 1'b0;
      last_win  <= 1'b0;
      ends_seen <= 1'b0;
      pad_cnt   <= 2'd0;
      ctrl_q    <= '0;
    end else begin
      state     <= state_next;
      phase_b   <= phase_b_next;
      last_win  <= last_win_next;
      ends_seen <= ends_seen_next;
      pad_cnt   <= pad_cnt_next;
      ctrl_q    <= ctrl_d;
    end
  end

  always_comb begin
    state_next     = state;
    phase_b_next   = 1'b0;
    last_win_next  = last_win;
    ends_seen_next = ends_seen;
    pad_cnt_next   = 2'd0;
    row_clr        = 1'b0;
    row_set_last   = 1'b0;
    row_inc        = 1'b0;
    case (state)
      IDLE: if (start) state_next = INIT;
      INIT: begin
        state_next     = RD_FILT;
        row_clr        = 1'b1;
        last_win_next  = 1'b0;
        ends_seen_next = 1'b0;
      end
      RD_FILT: begin
        phase_b_next = ~phase_b;
        if (phase_b && dp.filt_cout) state_next = RD_ROWS;
      end
      // Band rows 0..3 fill in order; after a shift only row 3 is refilled.
      RD_ROWS: begin
        phase_b_next = ~phase_b;
        if (phase_b && dp.input_j_cout) begin
          if (row == LAST_ROW) state_next = LD_TAB;
          else                 row_inc    = 1'b1;
        end
      end
      LD_TAB: state_next = CALC;
      CALC:   if (dp.calc_done) state_next = STORE;
      STORE: begin
        last_win_next  = dp.table_cout;
        ends_seen_next = dp.it_ends;
        state_next     = (dp.write_mem_cout || dp.table_cout) ? WR_MEM : LD_TAB;
      end
      WR_MEM: state_next = last_win ? PAD : LD_TAB;
      PAD: begin
        pad_cnt_next = pad_cnt + 2'd1;
        if (pad_cnt == 2'(PAD_CYCLES - 1)) state_next = ends_seen ? DONE : SHIFT;
      end
      SHIFT: begin
        row_set_last = 1'b1;
        state_next   = RD_ROWS;
      end
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    case (state_next)
      INIT: begin
        ctrl_d.x_en         = 1'b1;
        ctrl_d.y_en         = 1'b1;
        ctrl_d.z_en         = 1'b1;
        ctrl_d.in_count_ld  = 1'b1;
        ctrl_d.tab_count_ld = 1'b1;
        ctrl_d.mac_rst      = 1'b1;
      end
      RD_FILT: begin
        if (!phase_b_next) begin
          ctrl_d.mem_in_sel = SEL_X;
          ctrl_d.mem_read   = 1'b1;
        end else begin
          ctrl_d.filt_ld       = 1'b1;
          ctrl_d.filt_count_en = 1'b1;
          ctrl_d.x_en          = 1'b1;
          ctrl_d.x_sel         = 1'b1;
        end
      end
      // Row only moves at phase B or SHIFT, so the phase-A value is the one to write into.
      RD_ROWS: begin
        if (!phase_b_next) begin
          ctrl_d.mem_in_sel = SEL_Y;
          ctrl_d.mem_read   = 1'b1;
        end else begin
          ctrl_d.input_en       = 1'b1;
          ctrl_d.input_count_en = 1'b1;
          ctrl_d.y_en           = 1'b1;
          ctrl_d.y_sel          = 1'b1;
          ctrl_d.input_i_sel    = row;
        end
      end
      LD_TAB: begin
        ctrl_d.table_ld = 1'b1;
        ctrl_d.mac_rst  = 1'b1;
      end
      CALC: begin
        ctrl_d.mac_ld        = 1'b1;
        ctrl_d.calc_count_en = 1'b1;
        ctrl_d.filt_row_sel  = 1'b1;
      end
      STORE: begin
        ctrl_d.write_buf_ld = 1'b1;
        ctrl_d.wr_count_en  = 1'b1;
        ctrl_d.count_13_en  = 1'b1;
      end
      WR_MEM: begin
        ctrl_d.mem_in_sel  = SEL_Z;
        ctrl_d.mem_write   = 1'b1;
        ctrl_d.z_en        = 1'b1;
        ctrl_d.z_sel       = 1'b1;
        ctrl_d.wr_data_sel = last_win_next;
      end
      PAD: ctrl_d.wr_count_en = 1'b1;
      SHIFT: begin
        ctrl_d.shift_en     = 1'b1;
        ctrl_d.in_count_en  = 1'b1;
        ctrl_d.tab_count_ld = 1'b1;
      end
      DONE:    ctrl_d.done = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

`ifdef CORR_PERF_CNT_EN
  // Run-length counter: zeroed at INIT, counts active cycles, saturates, frozen in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (state == INIT) begin
      cycle_cnt <= '0;
    end else if (state != IDLE && state != DONE && cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end
`endif

  assign dp.x_sel          = ctrl_q.x_sel;
  assign dp.y_sel          = ctrl_q.y_sel;
  assign dp.z_sel          = ctrl_q.z_sel;
  assign dp.x_en           = ctrl_q.x_en;
  assign dp.y_en           = ctrl_q.y_en;
  assign dp.z_en           = ctrl_q.z_en;
  assign dp.mem_in_sel     = ctrl_q.mem_in_sel;
  assign dp.mem_read       = ctrl_q.mem_read;
  assign dp.mem_write      = ctrl_q.mem_write;
  assign dp.filt_ld        = ctrl_q.filt_ld;
  assign dp.filt_count_en  = ctrl_q.filt_count_en;
  assign dp.filt_row_sel   = ctrl_q.filt_row_sel;
  assign dp.input_en       = ctrl_q.input_en;
  assign dp.input_count_en = ctrl_q.input_count_en;
  assign dp.input_i_sel    = ctrl_q.input_i_sel;
  assign dp.shift_en       = ctrl_q.shift_en;
  assign dp.in_count_en    = ctrl_q.in_count_en;
  assign dp.in_count_ld    = ctrl_q.in_count_ld;
  assign dp.tab_count_ld   = ctrl_q.tab_count_ld;
  assign dp.count_13_en    = ctrl_q.count_13_en;
  assign dp.table_ld       = ctrl_q.table_ld;
  assign dp.mac_rst        = ctrl_q.mac_rst;
  assign dp.mac_ld         = ctrl_q.mac_ld;
  assign dp.calc_count_en  = ctrl_q.calc_count_en;
  assign dp.write_buf_ld   = ctrl_q.write_buf_ld;
  assign dp.wr_count_en    = ctrl_q.wr_count_en;
  assign dp.wr_data_sel    = ctrl_q.wr_data_sel;
  assign done              = ctrl_q.done;

endmodule

// File: tb/tb_corr_controller.sv
// Bench for corr_controller: directed vector table, reset abort, and full randomized runs
// compared cycle by cycle against a phase-sequence model built from the run structure.
module tb_corr_controller;
  import corr_ctrl_pkg::*;

  localparam int BANDS = 13;
  localparam int WINS  = 13;
  localparam int TAPS  = 16;

  typedef enum logic [3:0] {
    K_IDLE, K_INIT, K_FA, K_FB, K_RA, K_RB, K_LDTAB, K_CALC, K_STORE, K_WR, K_PAD, K_SHIFT, K_DONE
  } kind_e;

  typedef struct packed {
    logic       x_sel, y_sel, z_sel, x_en, y_en, z_en;
    logic [1:0] mem_in_sel;
    logic       mem_read, mem_write;
    logic       filt_ld, filt_count_en, filt_row_sel;
    logic       input_en, input_count_en;
    logic [1:0] input_i_sel;
    logic       shift_en, in_count_en, in_count_ld;
    logic       tab_count_ld, count_13_en, table_ld;
    logic       mac_rst, mac_ld, calc_count_en;
    logic       write_buf_ld, wr_count_en, wr_data_sel;
    logic       done;
  } outs_t;

  // flag bits: 0 filt_cout, 1 input_j_cout, 2 calc_done, 3 write_mem_cout, 4 table_cout, 5 it_ends
  typedef struct packed { kind_e k; logic [1:0] arg; logic [5:0] fl; } tok_t;
  typedef struct packed { logic start; logic [5:0] fl; kind_e k; logic [1:0] arg; } vec_t;

  logic clk, rst, start, done;
`ifdef CORR_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;
`endif

  corr_controller_if dp_if ();

  corr_controller dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dp    (dp_if),
`ifdef CORR_PERF_CNT_EN
    .cycle_cnt (cycle_cnt),
`endif
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  tok_t q[$];
  vec_t tbl[20];

  // Expected strobes for each phase, straight from the behavioural description.
  function automatic outs_t exp_outs(kind_e k, logic [1:0] arg);
    outs_t o;
    o = '0;
    case (k)
      K_INIT:  begin o.x_en = 1; o.y_en = 1; o.z_en = 1; o.in_count_ld = 1; o.tab_count_ld = 1; o.mac_rst = 1; end
      K_FA:    begin o.mem_in_sel = 2'd0; o.mem_read = 1; end
      K_FB:    begin o.filt_ld = 1; o.filt_count_en = 1; o.x_en = 1; o.x_sel = 1; end
      K_RA:    begin o.mem_in_sel = 2'd1; o.mem_read = 1; end
      K_RB:    begin o.input_en = 1; o.input_count_en = 1; o.y_en = 1; o.y_sel = 1; o.input_i_sel = arg; end
      K_LDTAB: begin o.table_ld = 1; o.mac_rst = 1; end
      K_CALC:  begin o.mac_ld = 1; o.calc_count_en = 1; o.filt_row_sel = 1; end
      K_STORE: begin o.write_buf_ld = 1; o.wr_count_en = 1; o.count_13_en = 1; end
      K_WR:    begin o.mem_in_sel = 2'd2; o.mem_write = 1; o.z_en = 1; o.z_sel = 1; o.wr_data_sel = arg[0]; end
      K_PAD:   o.wr_count_en = 1;
      K_SHIFT: begin o.shift_en = 1; o.in_count_en = 1; o.tab_count_ld = 1; end
      K_DONE:  o.done = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] exam_mask(kind_e k);
    case (k)
      K_FB:    return 6'b000001;
      K_RB:    return 6'b000010;
      K_CALC:  return 6'b000100;
      K_STORE: return 6'b111000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic outs_t sample();
    outs_t a;
    a = '{dp_if.x_sel, dp_if.y_sel, dp_if.z_sel, dp_if.x_en, dp_if.y_en, dp_if.z_en,
          dp_if.mem_in_sel, dp_if.mem_read, dp_if.mem_write,
          dp_if.filt_ld, dp_if.filt_count_en, dp_if.filt_row_sel,
          dp_if.input_en, dp_if.input_count_en, dp_if.input_i_sel,
          dp_if.shift_en, dp_if.in_count_en, dp_if.in_count_ld,
          dp_if.tab_count_ld, dp_if.count_13_en, dp_if.table_ld,
          dp_if.mac_rst, dp_if.mac_ld, dp_if.calc_count_en,
          dp_if.write_buf_ld, dp_if.wr_count_en, dp_if.wr_data_sel, done};
    return a;
  endfunction

  task automatic set_flags(input logic [5:0] f);
    dp_if.filt_cout      = f[0];
    dp_if.input_j_cout   = f[1];
    dp_if.calc_done      = f[2];
    dp_if.write_mem_cout = f[3];
    dp_if.table_cout     = f[4];
    dp_if.it_ends        = f[5];
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input kind_e k, input logic [1:0] a, input logic [5:0] f);
    tok_t t;
    t.k = k; t.arg = a; t.fl = f;
    q.push_back(t);
  endtask

  // Phase-by-phase sequence of one complete run, derived from image/filter geometry.
  task automatic build_run(input bit wm13);
    logic wm, tc, en;
    q.delete();
    push(K_INIT, 2'd0, 6'd0);
    for (int w = 0; w < ROW_WORDS; w++) begin
      push(K_FA, 2'd0, 6'd0);
      push(K_FB, 2'd0, {5'b0, w == ROW_WORDS - 1});
    end
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < ROW_WORDS; w++) begin
        push(K_RA, 2'd0, 6'd0);
        push(K_RB, 2'(r), {4'b0, w == ROW_WORDS - 1, 1'b0});
      end
    for (int b = 0; b < BANDS; b++) begin
      if (b > 0) begin
        push(K_SHIFT, 2'd0, 6'd0);
        for (int w = 0; w < ROW_WORDS; w++) begin
          push(K_RA, 2'd0, 6'd0);
          push(K_RB, 2'd3, {4'b0, w == ROW_WORDS - 1, 1'b0});
        end
      end
      for (int win = 1; win <= WINS; win++) begin
        push(K_LDTAB, 2'd0, 6'd0);
        for (int c = 0; c < TAPS; c++) push(K_CALC, 2'd0, {3'b0, c == TAPS - 1, 2'b0});
        tc = (win == WINS);
        wm = (win % 4 == 0) || (tc && wm13);
        en = tc && (b == BANDS - 1);
        push(K_STORE, 2'd0, {en, tc, wm, 3'b0});
        if (wm || tc) push(K_WR, {1'b0, tc}, 6'd0);
        if (tc) repeat (3) push(K_PAD, 2'd0, 6'd0);
      end
    end
  endtask

  // One run from IDLE; abort_at >= 0 pulls reset right after that phase is checked.
  task automatic run(input int idle_cyc, input int abort_at, input bit wm13);
    int    n_wr, n_part, n_mac, hold;
    outs_t act;
    logic [5:0] noise;
    n_wr = 0; n_part = 0; n_mac = 0;
    build_run(wm13);
    repeat (idle_cyc) begin
      @(negedge clk); start = 1'b0; set_flags(6'($urandom));
      check_outs("idle_wait", exp_outs(K_IDLE, 2'd0));
    end
    @(negedge clk); start = 1'b1; set_flags(6'd0);
    check_outs("idle_start", exp_outs(K_IDLE, 2'd0));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      noise = 6'($urandom) & ~exam_mask(q[i].k);
      set_flags(q[i].fl | noise);
      start = 1'($urandom);
      act = sample();
      if (act.mem_write) n_wr++;
      if (act.mem_write && act.wr_data_sel) n_part++;
      if (act.mac_ld) n_mac++;
      check_outs($sformatf("%s[%0d]", q[i].k.name(), i), exp_outs(q[i].k, q[i].arg));
      if (i == abort_at) begin
        #2 rst = 1'b0;
        #1 check_outs("reset_async", '0);
`ifdef CORR_PERF_CNT_EN
        check_int("reset_cycle_cnt", int'(cycle_cnt), 0);
`endif
        repeat (3) begin
          @(negedge clk); check_outs("reset_hold", '0);
        end
        rst = 1'b1; start = 1'b0; set_flags(6'd0);
        repeat (3) begin
          @(negedge clk); check_outs("idle_after_reset", exp_outs(K_IDLE, 2'd0));
        end
        return;
      end
    end
    hold = $urandom_range(1, 4);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); start = 1'b1; set_flags(6'($urandom));
      check_outs("done_hold", exp_outs(K_DONE, 2'd0));
`ifdef CORR_PERF_CNT_EN
      check_int("cycle_cnt_done", int'(cycle_cnt), q.size() - 1);
`endif
    end
    @(negedge clk); start = 1'b0; set_flags(6'd0);
    check_outs("done_release", exp_outs(K_DONE, 2'd0));
    @(negedge clk);
    check_outs("back_to_idle", exp_outs(K_IDLE, 2'd0));
    check_int("mem_writes", n_wr, BANDS * ((WINS + 3) / 4));
    check_int("partial_writes", n_part, BANDS);
    check_int("mac_pulses", n_mac, BANDS * WINS * TAPS);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 6'd0,      K_IDLE, 2'd0};
    tbl[1]  = '{1'b0, 6'b111111, K_IDLE, 2'd0};
    tbl[2]  = '{1'b1, 6'd0,      K_IDLE, 2'd0};
    tbl[3]  = '{1'b0, 6'd0,      K_INIT, 2'd0};
    tbl[4]  = '{1'b1, 6'b000001, K_FA,   2'd0};
    tbl[5]  = '{1'b0, 6'd0,      K_FB,   2'd0};
    tbl[6]  = '{1'b0, 6'd0,      K_FA,   2'd0};
    tbl[7]  = '{1'b0, 6'd0,      K_FB,   2'd0};
    tbl[8]  = '{1'b0, 6'd0,      K_FA,   2'd0};
    tbl[9]  = '{1'b0, 6'd0,      K_FB,   2'd0};
    tbl[10] = '{1'b0, 6'd0,      K_FA,   2'd0};
    tbl[11] = '{1'b0, 6'b000001, K_FB,   2'd0};
    tbl[12] = '{1'b0, 6'b000010, K_RA,   2'd0};
    tbl[13] = '{1'b0, 6'b000010, K_RB,   2'd0};
    tbl[14] = '{1'b0, 6'd0,      K_RA,   2'd0};
    tbl[15] = '{1'b0, 6'd0,      K_RB,   2'd1};
    tbl[16] = '{1'b0, 6'd0,      K_RA,   2'd0};
    tbl[17] = '{1'b0, 6'b000010, K_RB,   2'd1};
    tbl[18] = '{1'b0, 6'd0,      K_RA,   2'd0};
    tbl[19] = '{1'b0, 6'd0,      K_RB,   2'd2};

    rst = 1'b0; start = 1'b0; set_flags(6'd0);
    repeat (2) @(negedge clk);
    check_outs("reset_state", '0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = tbl[i].start;
      set_flags(tbl[i].fl);
      check_outs($sformatf("vec%0d_%s", i, tbl[i].k.name()), exp_outs(tbl[i].k, tbl[i].arg));
    end

    #2 rst = 1'b0;
    #1 check_outs("reset_mid_rows", '0);
    @(negedge clk); rst = 1'b1; start = 1'b0; set_flags(6'd0);

    run($urandom_range(1, 5), 42 + int'($urandom_range(0, TAPS - 1)), 1'b0);
    run($urandom_range(1, 5), -1, 1'b0);
    run($urandom_range(1, 5), -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
